hd44780_nibble_tx: RTL and testbench
====================================

Name: hd44780_nibble_tx

Overview:
- Transmit end of the HD44780-style 4-bit LCD bus. Its receiver is the bench nibble decoder, which captures on the EN falling edge.
- Accepts one byte per valid/ready handshake and serialises it as a high nibble then a low nibble, each strobed by an EN pulse.
- Enforces setup, pulse-width, hold and post-command execution delays.
- Sits between the LCD init/message sequencer (upstream) and the uo_out/uio_out pad mapping (downstream).

Parameters:
- T_SETUP, 2: cycles D/RS stable before EN rises (≥1).
- T_EN_HIGH, 12: cycles EN held high (≥1; 240 ns at 50 MHz).
- T_HOLD, 1: cycles D/RS held after EN falls (≥1).
- T_GAP, 50: cycles between high-nibble hold end and low-nibble setup start (≥1).
- T_CMD_WAIT, 2500: post-byte wait for ordinary commands and data (≥1; 50 µs).
- T_CLEAR_WAIT, 82000: post-byte wait for clear/home commands (≥1; 1.64 ms).
- T_INIT_WAIT, 205000: post-nibble wait after a single-nibble write (≥1; 4.1 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- in_valid  in  1  upstream has a byte.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  8  byte to send.
- in_rs  in  1  0 = command, 1 = data.
- in_single  in  1  send in_data[7:4] only (forced-init writes).
- lcd_d  out  4  LCD data nibble.
- lcd_rs  out  1  LCD register select.
- lcd_en  out  1  LCD enable strobe.
- busy  out  1  equals ~in_ready.

Behaviour:
- Reset: rst_n is synchronous, active-low. While it is low: state=IDLE, lcd_en=0, lcd_rs=0, lcd_d=0, counter=0, in_ready=0, busy=1. First edge with rst_n high: in_ready=1.
- All outputs are registered.
- Accept occurs on an edge where in_valid&in_ready=1 in IDLE. On that edge the block latches data, rs and single, and moves to SETUP_H. in_ready drops in the same edge.
- Phase sequence: SETUP_H(T_SETUP) → EN_H(T_EN_HIGH) → HOLD_H(T_HOLD) → [single ? WAIT : GAP(T_GAP) → SETUP_L(T_SETUP) → EN_L(T_EN_HIGH) → HOLD_L(T_HOLD) → WAIT] → IDLE.
- Each phase lasts exactly its parameter in cycles. A single down-counter is loaded on phase entry; the phase exits when the counter reaches 1.
- lcd_d per phase:
  - SETUP_H/EN_H/HOLD_H/GAP: data[7:4].
  - SETUP_L/EN_L/HOLD_L/WAIT: data[3:0], or data[7:4] if single.
  - IDLE: last value retained.
- lcd_rs = latched rs from SETUP_H through WAIT; retained in IDLE.
- lcd_en = 1 only in EN_H and EN_L.
- WAIT length:
  - single=1: T_INIT_WAIT.
  - rs=0 and data ∈ {0x01,0x02,0x03}: T_CLEAR_WAIT.
  - otherwise: T_CMD_WAIT.
- Latency, full byte: in_ready re-asserts 2·(T_SETUP+T_EN_HIGH+T_HOLD)+T_GAP+WAIT cycles after the accept edge. Defaults: 80+2500 = 2580 for ordinary bytes; 80+82000 for clear.
- Latency, single: T_SETUP+T_EN_HIGH+T_HOLD+T_INIT_WAIT cycles after the accept edge.
- in_data/in_rs/in_single changes after accept have no effect. in_valid while busy is ignored and is not queued.
- Back-to-back: if in_valid is held, the next byte is accepted on the first IDLE cycle. Exactly one IDLE cycle separates transfers.
- Exactly one EN falling edge per nibble. No glitches: EN rises only after D/RS are stable for ≥T_SETUP cycles.
- Reset mid-operation: at the next edge with rst_n=0, lcd_en=0 and the transfer is aborted, even mid-pulse. No partial-byte recovery.
- Counter width: $clog2(max parameter)+1 bits.

Test Plan:
- Reset, then accept 0x28 with rs=0, single=0 → nibbles 2 then 8 on lcd_d. Two EN pulses, each 12 cycles high; EN rises 2 cycles after D valid. in_ready returns 2580 cycles after accept. The bench decoder reports CMD 0x28.
- Send 0x01 with rs=0 → in_ready returns 82080 cycles after accept. Sending 0x01 with rs=1 gives the 2580-cycle wait.
- Send 0x30 with single=1, three times, then 0x20 with single=1 → exactly one EN pulse each, lcd_d=3,3,3,2. Each in_ready gap is 15+205000 cycles.
- Hold in_valid=1 over the sequence "THE GAME" with rs=1 → 16 EN falling edges; decoded bytes match the string; exactly one IDLE cycle between bytes; lcd_rs=1 throughout.
- Change in_data and pulse in_valid while busy → transmitted byte is unchanged and no extra transfer occurs.
- Assert rst_n=0 during EN_L → next edge has lcd_en=0, lcd_d=0, in_ready=0. After release, a new 0x0C transfers correctly.

Source files
------------

// File: rtl/hd44780_nibble_tx.sv
// rtl/hd44780_nibble_tx.sv - HD44780 4-bit bus transmitter: one byte per handshake, two EN-strobed nibbles.
// Each phase is timed by one down-counter that is loaded on entry; the phase ends when it reaches 1.
module hd44780_nibble_tx #(
    parameter int T_SETUP      = 2,
    parameter int T_EN_HIGH    = 12,
    parameter int T_HOLD       = 1,
    parameter int T_GAP        = 50,
    parameter int T_CMD_WAIT   = 2500,
    parameter int T_CLEAR_WAIT = 82000,
    parameter int T_INIT_WAIT  = 205000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    input  logic       in_single,
    output logic [3:0] lcd_d,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       busy
);

    localparam int MAX_A = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int MAX_C = (T_CMD_WAIT > T_CLEAR_WAIT) ? T_CMD_WAIT : T_CLEAR_WAIT;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_E = (MAX_C > T_INIT_WAIT) ? MAX_C : T_INIT_WAIT;
    localparam int MAX_P = (MAX_D > MAX_E) ? MAX_D : MAX_E;
    localparam int CW    = $clog2(MAX_P) + 1;
    localparam logic [CW-1:0] C_ONE = CW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP_H,
        S_EN_H,
        S_HOLD_H,
        S_GAP,
        S_SETUP_L,
        S_EN_L,
        S_HOLD_L,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_data;
    logic            r_rs;
    logic            r_single;
    logic [3:0]      r_lcd_d;
    logic            r_lcd_rs;
    logic            r_lcd_en;
    logic            r_ready;
    logic            r_busy;

    state_t          w_next_state;
    logic [CW-1:0]   w_next_cnt;
    logic [CW-1:0]   w_wait_len;
    logic            w_accept;
    logic [7:0]      w_data;
    logic            w_rs;
    logic            w_single;
    logic [3:0]      w_lcd_d;
    logic            w_lcd_rs;
    logic            w_lcd_en;

    function automatic logic [CW-1:0] f_len(input state_t s, input logic [CW-1:0] wait_len);
        case (s)
            S_SETUP_H, S_SETUP_L: f_len = CW'(T_SETUP);
            S_EN_H, S_EN_L:       f_len = CW'(T_EN_HIGH);
            S_HOLD_H, S_HOLD_L:   f_len = CW'(T_HOLD);
            S_GAP:                f_len = CW'(T_GAP);
            S_WAIT:               f_len = wait_len;
            default:              f_len = '0;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) commands need the long execution time.
    always_comb begin
        w_wait_len = CW'(T_CMD_WAIT);
        if (r_single)
            w_wait_len = CW'(T_INIT_WAIT);
        else if (!r_rs && (r_data inside {8'h01, 8'h02, 8'h03}))
            w_wait_len = CW'(T_CLEAR_WAIT);
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SETUP_H;
                end
            end
            S_SETUP_H: if (r_cnt == C_ONE) w_next_state = S_EN_H;
            S_EN_H:    if (r_cnt == C_ONE) w_next_state = S_HOLD_H;
            S_HOLD_H:  if (r_cnt == C_ONE) w_next_state = r_single ? S_WAIT : S_GAP;
            S_GAP:     if (r_cnt == C_ONE) w_next_state = S_SETUP_L;
            S_SETUP_L: if (r_cnt == C_ONE) w_next_state = S_EN_L;
            S_EN_L:    if (r_cnt == C_ONE) w_next_state = S_HOLD_L;
            S_HOLD_L:  if (r_cnt == C_ONE) w_next_state = S_WAIT;
            S_WAIT:    if (r_cnt == C_ONE) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase

        if (w_next_state != r_state)
            w_next_cnt = f_len(w_next_state, w_wait_len);
        else if (r_state == S_IDLE)
            w_next_cnt = r_cnt;
        else
            w_next_cnt = r_cnt - C_ONE;

        w_data   = w_accept ? in_data   : r_data;
        w_rs     = w_accept ? in_rs     : r_rs;
        w_single = w_accept ? in_single : r_single;

        // Outputs are derived from the next state so they change on the same edge as the phase.
        case (w_next_state)
            S_SETUP_H, S_EN_H, S_HOLD_H, S_GAP:
                w_lcd_d = w_data[7:4];
            S_SETUP_L, S_EN_L, S_HOLD_L, S_WAIT:
                w_lcd_d = w_single ? w_data[7:4] : w_data[3:0];
            default:
                w_lcd_d = r_lcd_d;
        endcase
        w_lcd_rs = (w_next_state == S_IDLE) ? r_lcd_rs : w_rs;
        w_lcd_en = (w_next_state == S_EN_H) || (w_next_state == S_EN_L);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_rs     <= 1'b0;
            r_single <= 1'b0;
            r_lcd_d  <= '0;
            r_lcd_rs <= 1'b0;
            r_lcd_en <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_data   <= w_data;
            r_rs     <= w_rs;
            r_single <= w_single;
            r_lcd_d  <= w_lcd_d;
            r_lcd_rs <= w_lcd_rs;
            r_lcd_en <= w_lcd_en;
            r_ready  <= (w_next_state == S_IDLE);
            r_busy   <= (w_next_state != S_IDLE);
        end
    end

    assign in_ready = r_ready;
    assign busy     = r_busy;
    assign lcd_d    = r_lcd_d;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_en   = r_lcd_en;

endmodule

// File: tb/tb_hd44780_nibble_tx.sv
// tb/tb_hd44780_nibble_tx.sv - randomized bench with a time-offset reference model and EN-fall nibble decoder.
module tb_hd44780_nibble_tx;

    localparam int TS = 2, TE = 3, TH = 1, TG = 4, TC = 20, TCL = 60, TI = 90;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic       in_single = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, busy, lcd_rs, lcd_en;
    logic [3:0] lcd_d;

    hd44780_nibble_tx #(
        .T_SETUP(TS), .T_EN_HIGH(TE), .T_HOLD(TH), .T_GAP(TG),
        .T_CMD_WAIT(TC), .T_CLEAR_WAIT(TCL), .T_INIT_WAIT(TI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_rs(in_rs), .in_single(in_single),
        .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_en(lcd_en), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: a transfer is a time offset into a fixed timeline of phase lengths.
    bit         m_started = 0, m_active = 0, m_ready = 0, m_rs = 0, m_single = 0;
    logic [7:0] m_byte = 0;
    int         m_t = 0, m_len = 0;
    logic [3:0] m_last_d = 0;
    logic       m_last_rs = 0;
    logic [4:0] exp_q[$];
    logic [4:0] dec_q[$];
    logic       prev_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int xfer_len(input logic [7:0] b, input logic rs, input logic single);
        int w;
        if (single) return TS + TE + TH + TI;
        w = (!rs && b >= 8'h01 && b <= 8'h03) ? TCL : TC;
        return 2 * (TS + TE + TH) + TG + w;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        m_started = 1;
        if (!rst_n) begin
            m_active = 0; m_ready = 0; m_last_d = 0; m_last_rs = 0;
            exp_q.delete();
        end else if (m_active) begin
            if (m_t == m_len - 1) begin
                m_active  = 0;
                m_ready   = 1;
                m_last_d  = m_single ? m_byte[7:4] : m_byte[3:0];
                m_last_rs = m_rs;
            end else begin
                m_t++;
            end
        end else if (m_ready && in_valid) begin
            m_byte = in_data; m_rs = in_rs; m_single = in_single;
            m_t = 0; m_len = xfer_len(in_data, in_rs, in_single);
            m_active = 1; m_ready = 0;
            exp_q.push_back({in_rs, in_data[7:4]});
            if (!in_single) exp_q.push_back({in_rs, in_data[3:0]});
        end else begin
            m_ready = 1;
        end
    end

    initial forever begin
        logic       e_en, e_rs, hi;
        logic [3:0] e_d;
        int         lo;
        @(negedge clk);
        if (m_started) begin
            if (m_active) begin
                lo   = 2 * TS + TE + TH + TG;
                hi   = m_single || (m_t < TS + TE + TH + TG);
                e_d  = hi ? m_byte[7:4] : m_byte[3:0];
                e_rs = m_rs;
                e_en = (m_t >= TS && m_t < TS + TE) ||
                       (!m_single && m_t >= lo && m_t < lo + TE);
            end else begin
                e_d = m_last_d; e_rs = m_last_rs; e_en = 1'b0;
            end
            chk("lcd_en", lcd_en, e_en);
            chk("lcd_d", lcd_d, e_d);
            chk("lcd_rs", lcd_rs, e_rs);
            chk("in_ready", in_ready, m_ready);
            chk("busy", busy, !m_ready);
            if (prev_en === 1'b1 && lcd_en === 1'b0 && rst_n) begin
                dec_q.push_back({lcd_rs, lcd_d});
                chk("fall_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("nibble", {lcd_rs, lcd_d}, exp_q.pop_front());
            end
            prev_en = lcd_en;
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", n < 1000, 1);
    endtask

    task automatic send(input logic [7:0] b, input logic rs, input logic single, input int exp_lat);
        int n, acc;
        wait_ready(n);
        in_data = b; in_rs = rs; in_single = single; in_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 1000) begin
            in_data = 8'($urandom); in_rs = 1'($urandom);
            in_single = 1'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("latency", cyc - acc, exp_lat);
    endtask

    initial begin
        int n, acc, prev_acc;
        string s;
        logic [7:0] b;
        logic rs, sg;
        logic [3:0] single_exp [4];
        single_exp = '{4'h3, 4'h3, 4'h3, 4'h2};

        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_d", lcd_d, 0);
        chk("rst_en", lcd_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        dec_q.delete();
        send(8'h28, 1'b0, 1'b0, 36);
        chk("dec_cnt_28", dec_q.size(), 2);
        if (dec_q.size() == 2) chk("dec_byte_28", {dec_q[0], dec_q[1][3:0]}, {1'b0, 8'h28});

        send(8'h01, 1'b0, 1'b0, 76);
        send(8'h01, 1'b1, 1'b0, 36);
        send(8'h02, 1'b0, 1'b0, 76);
        send(8'h03, 1'b0, 1'b0, 76);
        send(8'h04, 1'b0, 1'b0, 36);
        send(8'h00, 1'b0, 1'b0, 36);

        dec_q.delete();
        send(8'h30, 1'b0, 1'b1, 96);
        send(8'h30, 1'b0, 1'b1, 96);
        send(8'h30, 1'b0, 1'b1, 96);
        send(8'h20, 1'b0, 1'b1, 96);
        chk("single_cnt", dec_q.size(), 4);
        for (int i = 0; i < 4 && i < dec_q.size(); i++) chk("single_nib", dec_q[i][3:0], single_exp[i]);

        s = "THE GAME";
        dec_q.delete();
        prev_acc = 0;
        for (int i = 0; i < s.len(); i++) begin
            in_data = s[i]; in_rs = 1'b1; in_single = 1'b0; in_valid = 1'b1;
            wait_ready(n);
            @(negedge clk);
            acc = cyc;
            chk("b2b_ready_low", in_ready, 0);
            if (i > 0) chk("b2b_spacing", acc - prev_acc, 37);
            prev_acc = acc;
        end
        in_valid = 1'b0;
        wait_ready(n);
        chk("game_cnt", dec_q.size(), 16);
        for (int i = 0; i < s.len() && 2 * i + 1 < dec_q.size(); i++)
            chk("game_byte", {dec_q[2*i][4], dec_q[2*i+1][4], dec_q[2*i][3:0], dec_q[2*i+1][3:0]},
                {2'b11, s[i]});

        for (int k = 0; k < 12; k++) begin
            b = 8'($urandom); rs = 1'($urandom); sg = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin b = 8'($urandom_range(1, 3)); rs = 1'b0; end
            send(b, rs, sg, xfer_len(b, rs, sg));
        end

        wait_ready(n);
        in_data = 8'hA5; in_rs = 1'b1; in_single = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_abort_en", lcd_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_en", lcd_en, 0);
        chk("abort_d", lcd_d, 0);
        chk("abort_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        dec_q.delete();
        send(8'h0C, 1'b0, 1'b0, 36);
        chk("dec_cnt_0c", dec_q.size(), 2);
        if (dec_q.size() == 2) chk("dec_byte_0c", {dec_q[0][3:0], dec_q[1][3:0]}, 8'h0C);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
